// File: rtl/act_stream_pkg.sv
// Shared types and constants for the FP16 sigmoid stream adapter.
package act_stream_pkg;

  typedef logic [15:0] fp16_t;

  localparam int unsigned SIGMOID_LAT_A10 = 5;
  localparam int unsigned SIGMOID_LAT_S10 = 8;
  localparam fp16_t       FP16_HALF       = 16'h3800;

  function automatic int unsigned lat_for_family(bit a10);
    return a10 ? SIGMOID_LAT_A10 : SIGMOID_LAT_S10;
  endfunction

endpackage

// File: rtl/act_result_fifo.sv
// Synchronous show-ahead FIFO; head word is visible on dout whenever not empty.
module act_result_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 16,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             wr_en, rd_en;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  // A push into a full FIFO is only accepted when a pop frees the head slot.
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;
  assign dout  = mem[rd_ptr_q];
  assign count = count_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(wr_en) - CW'(rd_en);
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/act_stream_adapter.sv
// Ready/valid shim around the flow-control-free sigmoid core: rebuilds valid with a
// latency-matched shift register and credits a result FIFO so no result is ever dropped.
module act_stream_adapter
  import act_stream_pkg::*;
#(
  parameter int unsigned LATENCY    = lat_for_family(1'b1),
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DATA_W     = 16,
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] act_din,
  input  logic [DATA_W-1:0] act_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CW-1:0]     occupancy,
  output logic              overflow_err
);

  localparam int unsigned SW = CW + 1;

  logic [LATENCY-1:0] vld_sr_q;
  logic [CW-1:0]      inflight_q, inflight_d;
  logic [CW-1:0]      occupancy_q;
  logic [CW-1:0]      fifo_count, fifo_count_d;
  logic [SW-1:0]      credit_used;
  logic               overflow_q;
  logic               fire, push, pop, fifo_full, fifo_empty;

  assign act_din = in_data;

  // Every accepted element reserves a FIFO slot until it leaves the FIFO.
  assign credit_used = SW'(fifo_count) + SW'(inflight_q);
  assign in_ready    = resetn & (credit_used < SW'(FIFO_DEPTH));
  assign fire        = in_valid & in_ready;
  assign push        = vld_sr_q[LATENCY-1];
  assign out_valid   = ~fifo_empty;
  assign pop         = out_valid & out_ready;

  assign inflight_d   = inflight_q + CW'(fire) - CW'(push);
  assign fifo_count_d = fifo_count + CW'(push & (~fifo_full | pop)) - CW'(pop);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      vld_sr_q    <= '0;
      inflight_q  <= '0;
      occupancy_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      vld_sr_q    <= (vld_sr_q << 1) | LATENCY'(fire);
      inflight_q  <= inflight_d;
      occupancy_q <= fifo_count_d + inflight_d;
      overflow_q  <= overflow_q | (push & fifo_full & ~pop);
    end
  end

  assign occupancy    = occupancy_q;
  assign overflow_err = overflow_q;

  act_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .din    (act_dout),
    .dout   (out_data),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule
